// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master SDRAM Wishbone arbiter.
//   arb_state_t     : arbiter FSM state (IDLE, GNT0, GNT1)
//   master_id_t     : id of a requesting master (0 = video reader, 1 = writer)
//   DEFAULT_TIMEOUT : default slave-stall limit in sys_clk cycles
package wshb_arb_pkg;
   typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t;
   typedef logic master_id_t;
   localparam int DEFAULT_TIMEOUT = 1024;
endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle shared by the masters and the SDRAM slave.
//   master modport : drives cyc/stb/we/adr/dat_ms/sel/cti/bte, receives dat_sm/ack/err/rty
//   slave  modport : the reverse
interface wshb_if #(
   parameter int DATA_BYTES = 4,
   parameter int ADDR_W     = 32
);
   logic                    cyc, stb, we;
   logic [ADDR_W-1:0]       adr;
   logic [8*DATA_BYTES-1:0] dat_ms, dat_sm;
   logic [DATA_BYTES-1:0]   sel;
   logic [2:0]              cti;
   logic [1:0]              bte;
   logic                    ack, err, rty;

   modport master (output cyc, stb, we, adr, dat_ms, sel, cti, bte,
                   input  dat_sm, ack, err, rty);
   modport slave  (input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
                   output dat_sm, ack, err, rty);
endinterface

// File: rtl/wshb_arb_watchdog.sv
// Slave-stall watchdog for the SDRAM arbiter. Only built when the
// configuration macro WSHB_ARB_WATCHDOG_EN is defined.
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   state_i          : current arbiter state; any change restarts the count
//   stall_i          : owner has cyc&stb up and the slave gave no response
//   resp_i           : slave ack/err/rty this cycle
//   timeout_o        : one-cycle pulse on the TIMEOUT-th consecutive stall cycle
`ifdef WSHB_ARB_WATCHDOG_EN
module wshb_arb_watchdog
   import wshb_arb_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  arb_state_t state_i,
   input  logic       stall_i,
   input  logic       resp_i,
   output logic       timeout_o
);
   localparam int CW = $clog2(TIMEOUT + 1);

   arb_state_t    state_prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          clear;

   // A new owner's first stall cycle counts as 1, so the count is
   // restarted rather than zeroed when the grant changes.
   assign clear     = resp_i | (state_i != state_prev_q);
   assign timeout_o = stall_i & ~clear & (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (timeout_o)    cnt_d = '0;
      else if (clear)   cnt_d = stall_i ? CW'(1) : '0;
      else if (stall_i) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_q        <= '0;
         state_prev_q <= IDLE;
      end else begin
         cnt_q        <= cnt_d;
         state_prev_q <= state_i;
      end
   end
endmodule
`endif

// File: rtl/wshb_sdram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM slave port.
// A master owns the bus for as long as it holds cyc, so classic and burst
// cycles are never split. Request path and responses are combinational once
// granted; IDLE costs one cycle before the first grant.
// Optional: WSHB_ARB_WATCHDOG_EN adds a stall watchdog that errors out the
// owner after TIMEOUT stalled cycles and releases the bus.
//   TIMEOUT   : stall limit in sys_clk cycles (watchdog only)
//   sys_clk   : system clock
//   sys_rst   : asynchronous active-high reset
//   wshb_ifs0 : M0 port (video reader)
//   wshb_ifs1 : M1 port (writer)
//   wshb_ifm  : master port to the SDRAM slave
module wshb_sdram_arbiter
   import wshb_arb_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic   sys_clk,
   input  logic   sys_rst,
   wshb_if.slave  wshb_ifs0,
   wshb_if.slave  wshb_ifs1,
   wshb_if.master wshb_ifm
);
   arb_state_t state_q, state_d;
   master_id_t last_q, last_d;
   logic       cyc0, cyc1, own_req, resp, stall, timeout;

   assign cyc0 = wshb_ifs0.cyc;
   assign cyc1 = wshb_ifs1.cyc;
   assign resp = wshb_ifm.ack | wshb_ifm.err | wshb_ifm.rty;

   // Owner's raw strobe, taken before any watchdog masking so the stall
   // detect does not loop through the forced-low stb.
   always_comb begin
      own_req = 1'b0;
      case (state_q)
         GNT0:    own_req = wshb_ifs0.cyc & wshb_ifs0.stb;
         GNT1:    own_req = wshb_ifs1.cyc & wshb_ifs1.stb;
         default: own_req = 1'b0;
      endcase
   end

   assign stall = own_req & ~resp;

`ifdef WSHB_ARB_WATCHDOG_EN
   wshb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .state_i   (state_q),
      .stall_i   (stall),
      .resp_i    (resp),
      .timeout_o (timeout)
   );
`else
   logic unused_wdog;
   assign timeout     = 1'b0;
   assign unused_wdog = stall | (TIMEOUT != 0);
`endif

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;   // M0 wins the first tie after reset
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (cyc0 && cyc1)  state_d = (last_q == 1'b1) ? GNT0 : GNT1;
            else if (cyc0)     state_d = GNT0;
            else if (cyc1)     state_d = GNT1;
         end
         GNT0: begin
            if (timeout || !cyc0) begin
               last_d  = 1'b0;
               // Direct handover avoids a dead IDLE cycle when the other
               // master is already waiting; a watchdog abort always idles.
               state_d = (!timeout && cyc1) ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (timeout || !cyc1) begin
               last_d  = 1'b1;
               state_d = (!timeout && cyc0) ? GNT0 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request mux toward the slave and response routing to the owner only.
   // Read data is broadcast; without ack it is ignored by the non-owner.
   always_comb begin
      wshb_ifm.cyc    = 1'b0;
      wshb_ifm.stb    = 1'b0;
      wshb_ifm.we     = 1'b0;
      wshb_ifm.adr    = '0;
      wshb_ifm.dat_ms = '0;
      wshb_ifm.sel    = '0;
      wshb_ifm.cti    = '0;
      wshb_ifm.bte    = '0;
      wshb_ifs0.ack   = 1'b0;
      wshb_ifs0.err   = 1'b0;
      wshb_ifs0.rty   = 1'b0;
      wshb_ifs1.ack   = 1'b0;
      wshb_ifs1.err   = 1'b0;
      wshb_ifs1.rty   = 1'b0;
      wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
      wshb_ifs1.dat_sm = wshb_ifm.dat_sm;
      case (state_q)
         GNT0: begin
            wshb_ifm.cyc    = wshb_ifs0.cyc;
            wshb_ifm.stb    = wshb_ifs0.stb & ~timeout;
            wshb_ifm.we     = wshb_ifs0.we;
            wshb_ifm.adr    = wshb_ifs0.adr;
            wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
            wshb_ifm.sel    = wshb_ifs0.sel;
            wshb_ifm.cti    = wshb_ifs0.cti;
            wshb_ifm.bte    = wshb_ifs0.bte;
            wshb_ifs0.ack   = wshb_ifm.ack;
            wshb_ifs0.err   = wshb_ifm.err | timeout;
            wshb_ifs0.rty   = wshb_ifm.rty;
         end
         GNT1: begin
            wshb_ifm.cyc    = wshb_ifs1.cyc;
            wshb_ifm.stb    = wshb_ifs1.stb & ~timeout;
            wshb_ifm.we     = wshb_ifs1.we;
            wshb_ifm.adr    = wshb_ifs1.adr;
            wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
            wshb_ifm.sel    = wshb_ifs1.sel;
            wshb_ifm.cti    = wshb_ifs1.cti;
            wshb_ifm.bte    = wshb_ifs1.bte;
            wshb_ifs1.ack   = wshb_ifm.ack;
            wshb_ifs1.err   = wshb_ifm.err | timeout;
            wshb_ifs1.rty   = wshb_ifm.rty;
         end
         default: ;
      endcase
   end
endmodule

// File: doc/wshb_sdram_arbiter.md
# wshb_sdram_arbiter

Two-master Wishbone arbiter sharing the single SDRAM Wishbone slave port (`wshb_if_sdram`) of `hw_support` between the video frame-buffer reader (M0) and the pattern/frame writer (M1). Round-robin arbitration with cycle-level locking: a master keeps the bus for as long as it holds `cyc`, so classic and burst cycles are never split. Sits in `Top` between the video-side masters and `hw_support`, in the `sys_clk` domain.

## Interface
- `TIMEOUT`, 1024: slave-stall limit in `sys_clk` cycles; used only with the watchdog.
- `sys_clk`  in  1  system clock, 100 MHz.
- `sys_rst`  in  1  reset sys_rst, asynchronous, active-high; clock sys_clk.
- `wshb_ifs0`  `wshb_if.slave`  DATA_BYTES=4  M0 port (video reader, read-only in practice).
- `wshb_ifs1`  `wshb_if.slave`  DATA_BYTES=4  M1 port (writer).
- `wshb_ifm`  `wshb_if.master`  DATA_BYTES=4  to SDRAM slave of `hw_support`.

## Operation
- FSM states: IDLE, GNT0, GNT1. Register `last` (master id of previous owner).
- IDLE: `cyc0 & cyc1` -> grant master != `last`; only `cyc0` -> GNT0; only `cyc1` -> GNT1; none -> stay.
- GNTn: stay while `cycn`=1. When `cycn`=0: if other master's `cyc`=1 -> GNTother directly; else IDLE. Set `last`<=n on leaving GNTn.
- Granted master: `cyc, stb, we, adr, dat_ms, sel, cti, bte` muxed combinationally to `wshb_ifm`; slave `ack, err, rty` routed to it only.
- Non-granted master: `ack=err=rty=0`; `dat_sm` = slave `dat_sm` (broadcast, harmless).
- IDLE: `wshb_ifm.cyc=stb=we=0`, `adr, dat_ms, sel, cti, bte` = 0.
- Master dropping `cyc` mid-burst ends its ownership; no partial-cycle retention.
- Reset mid-transfer: state IDLE immediately, slave `cyc/stb` fall asynchronously; no ack forwarded.

## Timing
- Reset values: state IDLE, `last`=1 (M0 wins first tie), all `wshb_ifm` outputs 0, all master `ack/err/rty` 0.
- Grant latency: `cyc` seen in IDLE at edge t -> state GNTn after t; slave sees `cyc/stb` in cycle t+1 (one idle cycle).
- Handover latency: owner drops `cyc` in cycle t -> other master drives slave from cycle t+1; zero dead cycles beyond that.
- Data/ack path fully combinational: no added latency per beat after grant.
- Max wait for a requester: one full cycle of the other master (round-robin fairness).

## Configuration
- `WSHB_ARB_WATCHDOG_EN` defined: stall counter (width `$clog2(TIMEOUT+1)`) increments each cycle with slave `cyc&stb` and no `ack/err/rty`; cleared on any response or grant change. On reaching `TIMEOUT`: owner receives `err`=1 for exactly one cycle, slave `stb` forced 0 that cycle, state -> IDLE, `last`<=owner.
- Not defined: no counter; a stalled slave holds the bus indefinitely; `err` only from slave.

## Structure
- Package `wshb_arb_pkg`: `typedef enum logic[1:0] {IDLE, GNT0, GNT1} arb_state_t`; `typedef logic master_id_t`; `DEFAULT_TIMEOUT=1024`.
- Sub-module `wshb_arb_watchdog` (counter + timeout pulse), instantiated only under `WSHB_ARB_WATCHDOG_EN`.
- FSM, mux and response routing in the top module.

## Test plan
- Single M0 read, `adr`=0x100, slave acks after 2 cycles -> slave `cyc` high from cycle after request, M0 `ack` once, M1 `ack` never.
- M0 and M1 raise `cyc` same cycle after reset -> M0 granted first; M1 granted the cycle after M0 drops `cyc`.
- M0 8-beat burst (`cti`=010, final 111) with M1 requesting -> all 8 acks to M0 uninterrupted, then M1 served; `last`=0.
- Both masters request continuously, 1-beat cycles -> grants alternate M0,M1,M0,M1 over 8 cycles.
- Assert `sys_rst` mid-burst of M1 -> same cycle `wshb_ifm.cyc`=0, state IDLE; after release M0 wins a tie.
- With `WSHB_ARB_WATCHDOG_EN`, `TIMEOUT`=16, slave never acks -> M0 `err` pulse at 16th stall cycle, bus released, pending M1 granted next cycle.
